// File: rtl/cfg_sccb_sequencer.sv
// Camera bring-up sequencer: walks a {reg,val} table and issues each entry as an SCCB/I2C write,
// with optional read-back verify, NACK retries and inline millisecond delays.
module cfg_sccb_sequencer #(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter logic [6:0]  SLAVE_ADDR  = 7'h21,
  parameter int unsigned ROM_AW      = 8,
  parameter int unsigned MAX_RETRY   = 3,
  parameter bit          VERIFY      = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_wr,
  output logic              o_rd,
  output logic [6:0]        o_slave_addr,
  output logic [7:0]        o_reg_addr,
  output logic [7:0]        o_wdata,
  input  logic              i_busy,
  input  logic [7:0]        i_rdata,
  input  logic              i_rdata_valid,
  input  logic              i_nack_slave,
  input  logic              i_nack_addr,
  input  logic              i_nack_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ROM_AW-1:0] o_err_index,
  output logic [1:0]        o_err_code
);

  localparam int unsigned TickRaw    = CLK_FREQ_HZ / 1000;
  localparam int unsigned TickCycles = (TickRaw == 0) ? 1 : TickRaw;
  localparam int unsigned PreW       = (TickCycles > 1) ? $clog2(TickCycles) : 1;
  localparam logic [1:0]  CodeNack   = 2'b01;
  localparam logic [1:0]  CodeVerify = 2'b10;

  typedef enum logic [3:0] {
    StIdle, StWaitM, StFetch, StDecode, StDelay,
    StWrReq, StWrWait, StRdReq, StRdWait, StRetry
  } state_e;

  state_e            state_q, state_d;
  logic [ROM_AW-1:0] index_q, index_d;
  logic [15:0]       entry_q, entry_d;
  logic [3:0]        retry_q, retry_d;
  logic              nack_q, nack_d;
  logic              seen_q, seen_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [1:0]        code_q, code_d;
  logic [PreW-1:0]   pre_q, pre_d;
  logic [7:0]        ms_q, ms_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ROM_AW-1:0] err_index_q, err_index_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              advance;
  logic              nack_any;

  assign nack_any = i_nack_slave | i_nack_addr | i_nack_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      index_q     <= '0;
      entry_q     <= '0;
      retry_q     <= '0;
      nack_q      <= 1'b0;
      seen_q      <= 1'b0;
      rdata_q     <= '0;
      code_q      <= '0;
      pre_q       <= '0;
      ms_q        <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      entry_q     <= entry_d;
      retry_q     <= retry_d;
      nack_q      <= nack_d;
      seen_q      <= seen_d;
      rdata_q     <= rdata_d;
      code_q      <= code_d;
      pre_q       <= pre_d;
      ms_q        <= ms_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
      err_code_q  <= err_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    entry_d     = entry_q;
    retry_d     = retry_q;
    nack_d      = nack_q;
    seen_d      = seen_q;
    rdata_d     = rdata_q;
    code_d      = code_q;
    pre_d       = pre_q;
    ms_d        = ms_q;
    done_d      = done_q;
    error_d     = error_q;
    err_index_d = err_index_q;
    err_code_d  = err_code_q;
    advance     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d     = StWaitM;
          done_d      = 1'b0;
          error_d     = 1'b0;
          err_index_d = '0;
          err_code_d  = '0;
          index_d     = '0;
          retry_d     = '0;
        end
      end
      StWaitM: begin
        if (!i_busy) state_d = StFetch;
      end
      // ROM output is valid one cycle after the address moves.
      StFetch: state_d = StDecode;
      StDecode: begin
        if (i_rom_data == 16'hFFFF) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (i_rom_data[15:8] == 8'hFE) begin
          if (i_rom_data[7:0] == 8'h00) begin
            advance = 1'b1;
          end else begin
            ms_d    = i_rom_data[7:0];
            pre_d   = '0;
            state_d = StDelay;
          end
        end else begin
          entry_d = i_rom_data;
          nack_d  = 1'b0;
          state_d = StWrReq;
        end
      end
      StDelay: begin
        if (pre_q == PreW'(TickCycles - 1)) begin
          pre_d = '0;
          if (ms_q == 8'd1) advance = 1'b1;
          else              ms_d = ms_q - 8'd1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      StWrReq: begin
        if (i_busy) begin
          nack_d  = nack_q | nack_any;
          state_d = StWrWait;
        end
      end
      StWrWait: begin
        if (i_busy) begin
          nack_d = nack_q | nack_any;
        end else if (nack_q) begin
          code_d  = CodeNack;
          state_d = StRetry;
        end else if (VERIFY) begin
          nack_d  = 1'b0;
          seen_d  = 1'b0;
          state_d = StRdReq;
        end else begin
          advance = 1'b1;
        end
      end
      // o_rd stays up across the address and read phases; dropping it on valid data keeps the
      // master from relaunching once it returns idle.
      StRdReq: begin
        if (i_busy) begin
          nack_d = nack_q | nack_any;
          seen_d = 1'b1;
          if (i_rdata_valid) begin
            rdata_d = i_rdata;
            state_d = StRdWait;
          end
        end else if (seen_q) begin
          code_d  = nack_q ? CodeNack : CodeVerify;
          state_d = StRetry;
        end
      end
      StRdWait: begin
        if (i_busy) begin
          nack_d = nack_q | nack_any;
        end else if (nack_q) begin
          code_d  = CodeNack;
          state_d = StRetry;
        end else if (rdata_q != entry_q[7:0]) begin
          code_d  = CodeVerify;
          state_d = StRetry;
        end else begin
          advance = 1'b1;
        end
      end
      StRetry: begin
        if (retry_q < 4'(MAX_RETRY)) begin
          retry_d = retry_q + 4'd1;
          nack_d  = 1'b0;
          state_d = StWrReq;
        end else begin
          error_d     = 1'b1;
          err_index_d = index_q;
          err_code_d  = code_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A table with no end marker finishes cleanly when the index would wrap.
    if (advance) begin
      retry_d = '0;
      if (index_q == {ROM_AW{1'b1}}) begin
        done_d  = 1'b1;
        state_d = StIdle;
      end else begin
        index_d = index_q + 1'b1;
        state_d = StFetch;
      end
    end
  end

  assign o_rom_addr   = index_q;
  assign o_slave_addr = SLAVE_ADDR;
  assign o_reg_addr   = entry_q[15:8];
  assign o_wdata      = entry_q[7:0];
  assign o_wr         = (state_q == StWrReq);
  assign o_rd         = (state_q == StRdReq);
  assign o_busy       = (state_q != StIdle);
  assign o_done       = done_q;
  assign o_error      = error_q;
  assign o_err_index  = err_index_q;
  assign o_err_code   = err_code_q;

endmodule

// File: tb/tb_cfg_sccb_sequencer.sv
// Bench for cfg_sccb_sequencer: three parameterisations share one behavioural I2C master/slave
// model; every launched transfer is checked against a queue of expected transfers.
module tb_cfg_sccb_sequencer;

  localparam int unsigned NumDut = 3;
  localparam int unsigned MaxRetry [NumDut] = '{3, 2, 3};
  localparam bit          Verify   [NumDut] = '{1'b0, 1'b0, 1'b1};
  localparam int unsigned ClkHz  = 100000;  // 100 cycles per ms
  localparam int          WrLen  = 6;
  localparam int          RdLen  = 12;
  localparam int          PwrLen = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NumDut-1:0] start = '0;
  logic [NumDut-1:0] wr, rd, busy, done, error;
  logic [7:0]        rom_addr  [NumDut];
  logic [7:0]        err_index [NumDut];
  logic [7:0]        reg_addr  [NumDut];
  logic [7:0]        wdata     [NumDut];
  logic [6:0]        slave_addr[NumDut];
  logic [1:0]        err_code  [NumDut];
  logic [15:0]       rom [256];

  logic       m_busy, m_valid, m_nack, m_is_rd, m_pwr, m_nack_now;
  logic [7:0] m_rdata, m_reg, m_val;
  logic [7:0] mem [256];
  int         m_cnt, m_len;

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    logic [15:0] rom_q;
    always @(posedge clk) rom_q <= rom[rom_addr[g]];

    cfg_sccb_sequencer #(
      .CLK_FREQ_HZ(ClkHz),
      .SLAVE_ADDR (7'h21),
      .ROM_AW     (8),
      .MAX_RETRY  (MaxRetry[g]),
      .VERIFY     (Verify[g])
    ) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start[g]),
      .o_rom_addr   (rom_addr[g]),
      .i_rom_data   (rom_q),
      .o_wr         (wr[g]),
      .o_rd         (rd[g]),
      .o_slave_addr (slave_addr[g]),
      .o_reg_addr   (reg_addr[g]),
      .o_wdata      (wdata[g]),
      .i_busy       (m_busy),
      .i_rdata      (m_rdata),
      .i_rdata_valid(m_valid),
      .i_nack_slave (1'b0),
      .i_nack_addr  (m_nack),
      .i_nack_data  (1'b0),
      .o_busy       (busy[g]),
      .o_done       (done[g]),
      .o_error      (error[g]),
      .o_err_index  (err_index[g]),
      .o_err_code   (err_code[g])
    );
  end

  int          sel = 0;
  logic        s_wr, s_rd;
  logic [7:0]  s_reg, s_wdata;
  assign s_wr    = wr[sel];
  assign s_rd    = rd[sel];
  assign s_reg   = reg_addr[sel];
  assign s_wdata = wdata[sel];

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_wr = 0;
  int          n_rd = 0;
  int          cyc = 0;
  int          nack_left = 0;  // -1 = NACK every write
  int          bad_reg = -1;   // register whose readback is forced to 8'h00
  int          launch_t[$];
  logic [16:0] exp_q[$];
  logic [16:0] exp_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Cycle-level master + slave: address-byte NACK on request, readback from slave memory.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy     <= 1'b1;
      m_pwr      <= 1'b1;
      m_cnt      <= 0;
      m_len      <= PwrLen;
      m_valid    <= 1'b0;
      m_nack     <= 1'b0;
      m_is_rd    <= 1'b0;
      m_nack_now <= 1'b0;
      m_rdata    <= '0;
      m_reg      <= '0;
      m_val      <= '0;
    end else begin
      cyc = cyc + 1;
      if (!m_busy) begin
        if (s_wr || s_rd) begin
          check("wr_rd_exclusive", {31'd0, s_wr & s_rd}, 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_xfer", {15'd0, s_rd, s_reg, s_wdata}, 32'hFFFFFFFF);
          end else begin
            exp_e = exp_q.pop_front();
            check("xfer", {15'd0, s_rd, s_reg, (s_rd ? 8'h00 : s_wdata)}, {15'd0, exp_e});
          end
          launch_t.push_back(cyc);
          m_busy  <= 1'b1;
          m_pwr   <= 1'b0;
          m_cnt   <= 0;
          m_is_rd <= s_rd;
          m_len   <= s_rd ? RdLen : WrLen;
          m_reg   <= s_reg;
          m_val   <= s_wdata;
          if (s_rd) n_rd = n_rd + 1;
          else      n_wr = n_wr + 1;
          if (!s_rd && nack_left != 0) begin
            m_nack_now <= 1'b1;
            if (nack_left > 0) nack_left = nack_left - 1;
          end else begin
            m_nack_now <= 1'b0;
          end
        end
      end else begin
        m_cnt   <= m_cnt + 1;
        m_valid <= (m_is_rd && !m_pwr && m_cnt == m_len - 4);
        if (!m_pwr && m_cnt == 2 && m_nack_now) m_nack <= 1'b1;
        if (m_is_rd && m_cnt == m_len - 4) m_rdata <= (bad_reg == int'(m_reg)) ? 8'h00 : mem[m_reg];
        if (m_cnt == m_len - 1) begin
          m_busy  <= 1'b0;
          m_nack  <= 1'b0;
          m_valid <= 1'b0;
          if (!m_pwr && !m_is_rd && !m_nack_now) mem[m_reg] <= m_val;
          if (!m_pwr && m_is_rd) check("rd_dropped_before_idle", {31'd0, s_rd}, 32'd0);
        end
      end
    end
  end

  task automatic load(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                      input logic [15:0] w3);
    rom[0] = w0;
    rom[1] = w1;
    rom[2] = w2;
    rom[3] = w3;
  endtask

  task automatic push(input logic is_rd, input logic [7:0] ra, input logic [7:0] val);
    exp_q.push_back({is_rd, ra, (is_rd ? 8'h00 : val)});
  endtask

  task automatic clear_stats();
    n_wr = 0;
    n_rd = 0;
    launch_t.delete();
  endtask

  task automatic run_seq(input int idx, input int budget);
    @(negedge clk);
    start[idx] = 1'b1;
    @(negedge clk);
    start[idx] = 1'b0;
    for (int i = 0; i < budget && busy[idx]; i++) @(negedge clk);
    check("seq_timeout", {31'd0, busy[idx]}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    repeat (3) @(negedge clk);
    check("rst_wr", {29'd0, wr}, 32'd0);
    check("rst_busy", {29'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_done_err", {26'd0, done, error}, 32'd0);
    check("rst_rd", {29'd0, rd}, 32'd0);
    check("rst_slave_addr", {25'd0, slave_addr[0]}, 32'h21);
    check("rst_err_code", {30'd0, err_code[0]}, 32'd0);

    // Write, 10 ms delay, write.
    sel = 0;
    clear_stats();
    load(16'h8012, 16'hFE0A, 16'h1101, 16'hFFFF);
    push(1'b0, 8'h80, 8'h12);
    push(1'b0, 8'h11, 8'h01);
    run_seq(0, 5000);
    check("t1_done", {31'd0, done[0]}, 32'd1);
    check("t1_error", {31'd0, error[0]}, 32'd0);
    check("t1_writes", n_wr, 2);
    check("t1_reads", n_rd, 0);
    check("t1_gap_ge_10ms", {31'd0, (launch_t[1] - launch_t[0]) >= 1000}, 32'd1);
    check("t1_gap_bounded", {31'd0, (launch_t[1] - launch_t[0]) < 1100}, 32'd1);
    check("t1_sb_drain", exp_q.size(), 0);

    // Two NACKs on entry 0, then ACK.
    clear_stats();
    load(16'h8012, 16'h1101, 16'hFFFF, 16'hFFFF);
    nack_left = 2;
    repeat (3) push(1'b0, 8'h80, 8'h12);
    push(1'b0, 8'h11, 8'h01);
    run_seq(0, 2000);
    check("t2_done", {31'd0, done[0]}, 32'd1);
    check("t2_error", {31'd0, error[0]}, 32'd0);
    check("t2_writes", n_wr, 4);
    check("t2_sb_drain", exp_q.size(), 0);

    // Permanent NACK with MAX_RETRY=2.
    sel = 1;
    clear_stats();
    load(16'h8012, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    nack_left = -1;
    repeat (3) push(1'b0, 8'h80, 8'h12);
    run_seq(1, 2000);
    nack_left = 0;
    check("t3_error", {31'd0, error[1]}, 32'd1);
    check("t3_done", {31'd0, done[1]}, 32'd0);
    check("t3_err_index", {24'd0, err_index[1]}, 32'd0);
    check("t3_err_code", {30'd0, err_code[1]}, 32'd1);
    check("t3_writes", n_wr, 3);
    check("t3_sb_drain", exp_q.size(), 0);

    // Verify mismatch on every attempt.
    sel = 2;
    clear_stats();
    load(16'h1101, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    bad_reg = 8'h11;
    repeat (4) begin
      push(1'b0, 8'h11, 8'h01);
      push(1'b1, 8'h11, 8'h00);
    end
    run_seq(2, 3000);
    bad_reg = -1;
    check("t4_error", {31'd0, error[2]}, 32'd1);
    check("t4_err_code", {30'd0, err_code[2]}, 32'd2);
    check("t4_err_index", {24'd0, err_index[2]}, 32'd0);
    check("t4_writes", n_wr, 4);
    check("t4_reads", n_rd, 4);
    check("t4_sb_drain", exp_q.size(), 0);

    // Verify with matching readback.
    clear_stats();
    load(16'h8012, 16'h1101, 16'hFFFF, 16'hFFFF);
    push(1'b0, 8'h80, 8'h12);
    push(1'b1, 8'h80, 8'h00);
    push(1'b0, 8'h11, 8'h01);
    push(1'b1, 8'h11, 8'h00);
    run_seq(2, 3000);
    repeat (20) @(negedge clk);
    check("t5_done", {31'd0, done[2]}, 32'd1);
    check("t5_error", {31'd0, error[2]}, 32'd0);
    check("t5_reads", n_rd, 2);
    check("t5_writes", n_wr, 2);
    check("t5_sb_drain", exp_q.size(), 0);

    // Reset while waiting on a write, then restart from entry 0.
    sel = 0;
    clear_stats();
    load(16'h8012, 16'h1101, 16'hFFFF, 16'hFFFF);
    push(1'b0, 8'h80, 8'h12);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 200 && n_wr == 0; i++) @(negedge clk);
    check("t6_first_launch", n_wr, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_wr_in_reset", {31'd0, wr[0]}, 32'd0);
    check("t6_busy_in_reset", {31'd0, busy[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    push(1'b0, 8'h80, 8'h12);
    push(1'b0, 8'h11, 8'h01);
    run_seq(0, 2000);
    check("t6_done", {31'd0, done[0]}, 32'd1);
    check("t6_writes", n_wr, 2);
    check("t6_sb_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cfg_sccb_sequencer.md
Name: cfg_sccb_sequencer

Overview:
- Walks a table of camera register/value pairs and issues each one as a write through the cfg_i2c_master.
- Optionally reads each register back and compares it with the table value.
- Retries transfers that are NACKed, and supports inline millisecond delays (e.g. after a soft reset).
- Sits between the camera-init table ROM and cfg_i2c_master, and reports done/error to the top-level bring-up logic.

Parameters:
- CLK_FREQ_HZ, 100000000, i_clk frequency; sets the 1 ms tick period.
- SLAVE_ADDR, 7'h21, 7-bit camera address driven on o_slave_addr.
- ROM_AW, 8, table address width.
- MAX_RETRY, 3, retries per entry after the first attempt (0..15).
- VERIFY, 0, 1 = read back each written register and compare.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset. One clock; reset is asynchronous and active-high.
- i_start  in  1  pulse; begins the sequence from entry 0.
- o_rom_addr  out  ROM_AW  table address
- i_rom_data  in  16  table word {reg[15:8], val[7:0]}; valid 1 cycle after o_rom_addr changes.
- o_wr  out  1  write request to the master
- o_rd  out  1  read request to the master
- o_slave_addr  out  7  constant SLAVE_ADDR
- o_reg_addr  out  8  register address
- o_wdata  out  8  write data
- i_busy  in  1  master busy
- i_rdata  in  8  master read data
- i_rdata_valid  in  1  master read-data valid
- i_nack_slave / i_nack_addr / i_nack_data  in  1 each  master NACK flags
- o_busy  out  1  sequence in progress
- o_done  out  1  sticky; sequence finished without error
- o_error  out  1  sticky; sequence aborted
- o_err_index  out  ROM_AW  entry index at abort
- o_err_code  out  2  abort cause: 01 NACK retries exhausted, 10 verify mismatch retries exhausted

Behaviour:
- Reset values: all outputs 0, except o_slave_addr = SLAVE_ADDR. State = IDLE.
- Table encoding:
  - 16'hFFFF = end of table.
  - 16'hFE_nn = delay nn ms; nn=0 means no delay.
  - Any other word = write val to reg.
- IDLE: on i_start go to WAIT_M; o_busy=1; o_done and o_error clear; index=0; retry=0. i_start is ignored while o_busy=1.
- WAIT_M: wait for i_busy=0. The master powers up busy, so this also covers startup. Then go to FETCH.
- FETCH: drive o_rom_addr = index; wait 1 cycle; latch i_rom_data; decode.
  - End marker: o_done=1, o_busy=0, go to IDLE.
  - Delay entry: go to DELAY.
  - Otherwise: go to WR_REQ.
- DELAY:
  - Prescaler counts CLK_FREQ_HZ/1000 cycles per ms tick; the ms counter counts nn ticks.
  - Then index+1, go to FETCH.
- WR_REQ:
  - Assert o_wr with o_reg_addr/o_wdata. Clear the sticky NACK latch.
  - Keep o_wr high until i_busy=1, then drop it. Hold o_reg_addr/o_wdata stable until i_busy=0, since the master samples them live during START.
- WR_WAIT:
  - While i_busy=1, OR-accumulate i_nack_slave|i_nack_addr|i_nack_data into the sticky latch. The master clears its flags in the same cycle busy falls.
  - On i_busy=0: if the latch is set, go to RETRY. Else if VERIFY=1, go to RD_REQ. Else index+1, retry=0, go to FETCH.
- RD_REQ / RD_WAIT:
  - Assert o_rd with o_reg_addr held; clear the latch.
  - Keep o_rd high through both master phases. Drop o_rd the first cycle i_busy=1 and i_rdata_valid=1, registering i_rdata. This stops the master from re-launching when it returns to idle.
  - Accumulate NACKs as in WR_WAIT, then wait for i_busy=0.
  - NACK latch set: RETRY with code 01. rdata≠val: RETRY with code 10. Otherwise advance as above.
- RETRY:
  - If retry<MAX_RETRY: retry+1, go to WR_REQ. The full write is re-issued even when only the verify failed.
  - Else: o_error=1, o_err_index=index, o_err_code set, o_busy=0, go to IDLE.
- o_wr and o_rd are never both high. Neither is asserted while i_busy=1 from a prior transfer.
- index wraps at 2^ROM_AW with no end marker present: treated as an end marker, so the sequence finishes as done.
- Asynchronous i_rst mid-transfer returns to IDLE with o_wr/o_rd=0. The master is reset by the same reset.

Test Plan:
- Table {12'h80 write 12h, FE 0A, 11 01, FFFF}, ideal slave model, VERIFY=0:
  - exactly 2 write transfers;
  - a ≥10 ms gap between them (CLK_FREQ_HZ scaled down in the bench);
  - o_done=1; o_error=0.
- Slave NACKs the address byte on entry 0 twice then ACKs, MAX_RETRY=3: 3 write attempts, then continue; o_done=1.
- Slave always NACKs, MAX_RETRY=2: 3 attempts, then o_error=1, o_err_index=0, o_err_code=01, o_busy=0.
- VERIFY=1, slave returns 8'h00 for reg 8'h11 written with 8'h01:
  - each attempt is a write plus a read;
  - o_error=1, o_err_code=10 after MAX_RETRY+1 attempts.
- VERIFY=1, matching readback: exactly one read per entry; o_rd deasserts before the master returns idle, with no spurious second read; o_done=1.
- Assert i_rst during WR_WAIT: o_wr=0, o_busy=0 immediately. A following i_start restarts from entry 0.
